// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and divisor floor.
// Used by the receive engine, register block and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int UART_MIN_DIV = 4;

  function automatic logic [15:0] eff_div(
    input logic [15:0] d,
    input logic [15:0] m
  );
    return (d < m) ? m : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO, show-ahead read, distributed RAM storage.
// Push while full is accepted only when a pop frees the slot.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    wdata,
  input  logic          push,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? 8'h00 : mem[rptr];

  // storage write, no reset on the RAM itself
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // pointers wrap naturally at DEPTH; level tracks occupancy
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      if (push_ok && !pop_ok)      level <= level + LW'(1);
      else if (pop_ok && !push_ok) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART 8N1 receiver: synchronizer, bit-timing FSM, byte FIFO
// and sticky frame/overrun error flags.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int MIN_DIV = UART_MIN_DIV,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rx_en,
  input  logic [15:0]   clk_div,
  input  logic          uart_rx,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [LW-1:0] rx_level,
  output logic          frame_err,
  output logic          overrun,
  input  logic          err_clr
);

  rx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] div_q, div_n;
  logic [2:0]  bitcnt, bit_n;
  logic [7:0]  shreg, sh_n;
  logic        s1, s2, rxs, rxs_d;
  logic        push, ferr_set;
  logic        full, empty, pop;

  assign rxs = s2;
  assign pop = rx_valid && rx_ready;

  // two-flop synchronizer plus edge-detect history, idle high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      s1    <= uart_rx;
      s2    <= s1;
      rxs_d <= s2;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      div_q  <= 16'(MIN_DIV);
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      div_q  <= div_n;
      bitcnt <= bit_n;
      shreg  <= sh_n;
    end
  end

  // bit timing: half period to mid start bit, then full periods
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 16'd1;
    div_n    = div_q;
    bit_n    = bitcnt;
    sh_n     = shreg;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_en && rxs_d && !rxs) begin
          state_n = START;
          div_n   = eff_div(clk_div, 16'(MIN_DIV));
        end
      end
      START: begin
        if (cnt == (div_q >> 1) - 16'd1) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == div_q - 16'd1) begin
          cnt_n = '0;
          sh_n  = {rxs, shreg[7:1]};
          bit_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == div_q - 16'd1) begin
          cnt_n    = '0;
          state_n  = IDLE;
          push     = rxs;
          ferr_set = !rxs;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // sticky flags; a same-cycle set wins over err_clr
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (push && full && !pop) overrun <= 1'b1;
      else if (err_clr)         overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wdata  (shreg),
    .push   (push),
    .pop    (pop),
    .rdata  (rx_data),
    .level  (rx_level),
    .full   (full),
    .empty  (empty)
  );

  assign rx_valid = !empty;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: frame vector table
// plus sequences for glitch, overrun, full push/pop and reset.
module tb_uart_rx_engine;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_en = 1'b1;
  logic [15:0] clk_div = 16'd16;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [3:0]  rx_level;
  logic        frame_err;
  logic        overrun;
  logic        err_clr = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_engine #(.DEPTH(8), .MIN_DIV(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_en     (rx_en),
    .clk_div   (clk_div),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_level  (rx_level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic        stop;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int effd(input logic [15:0] d);
    return (d < 16'd4) ? 4 : int'(d);
  endfunction

  // all tasks start and end 1 time unit after a rising edge
  task automatic send(input logic [7:0] b, input logic stp,
                      input int d);
    uart_rx = 1'b0;
    repeat (d) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (d) @(posedge clk);
      #1;
    end
    uart_rx = stp;
    repeat (d) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic watch(input int d, output int n);
    logic [3:0] l0;
    logic       f0, o0;
    l0 = rx_level;
    f0 = frame_err;
    o0 = overrun;
    n = 0;
    while (n < 20 * d + 50) begin
      @(posedge clk);
      #1;
      n++;
      if (rx_level != l0 || frame_err != f0 || overrun != o0)
        break;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic stp,
                       output int n);
    int d;
    int m;
    d = effd(clk_div);
    fork
      send(b, stp, d);
      watch(d, m);
    join
    n = m;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk(nm, {31'd0, rx_valid}, 32'd1);
    chk(nm, {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int n, d, lat;
    logic [7:0] exp_q [$];

    vecs[0] = '{16'd16, 8'h55, 1'b1};
    vecs[1] = '{16'd16, 8'hA3, 1'b0};
    vecs[2] = '{16'd5,  8'hC1, 1'b1};
    vecs[3] = '{16'd2,  8'h3C, 1'b1};
    vecs[4] = '{16'd0,  8'hFF, 1'b1};
    vecs[5] = '{16'd7,  8'h80, 1'b1};
    vecs[6] = '{16'd31, 8'h01, 1'b1};
    vecs[7] = '{16'd4,  8'h7E, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_level", {28'd0, rx_level}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      clk_div = vecs[v].div;
      d = effd(clk_div);
      lat = 3 + d / 2 + 9 * d;
      frame(vecs[v].data, vecs[v].stop, n);
      chk("vec_latency", n, lat);
      if (vecs[v].stop) begin
        chk("vec_ferr", {31'd0, frame_err}, 32'd0);
        chk("vec_level", {28'd0, rx_level}, 32'd1);
        pop_chk("vec_data", vecs[v].data);
      end else begin
        chk("vec_ferr", {31'd0, frame_err}, 32'd1);
        chk("vec_level", {28'd0, rx_level}, 32'd0);
        pulse_clr();
        chk("vec_ferr_clr", {31'd0, frame_err}, 32'd0);
      end
      chk("vec_empty", {28'd0, rx_level}, 32'd0);
    end

    // short low glitch is rejected at the start-bit sample
    clk_div = 16'd16;
    uart_rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("glitch_level", {28'd0, rx_level}, 32'd0);
    chk("glitch_ferr", {31'd0, frame_err}, 32'd0);
    chk("glitch_state", {30'd0, dut.state}, 32'd0);

    // rx_en low: no frame starts
    rx_en = 1'b0;
    frame(8'h5A, 1'b1, n);
    chk("rxen_off", {28'd0, rx_level}, 32'd0);
    rx_en = 1'b1;

    // rx_en dropped mid-frame: frame completes
    fork
      frame(8'h96, 1'b1, n);
      begin
        repeat (60) @(posedge clk);
        #1;
        rx_en = 1'b0;
      end
    join
    rx_en = 1'b1;
    chk("rxen_mid", {28'd0, rx_level}, 32'd1);
    pop_chk("rxen_mid_data", 8'h96);

    // fill past full: ninth byte dropped
    clk_div = 16'd4;
    for (int i = 0; i < 9; i++) frame(8'(i), 1'b1, n);
    chk("ovr_level", {28'd0, rx_level}, 32'd8);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_head", {24'd0, rx_data}, 32'd0);
    for (int i = 0; i < 8; i++) pop_chk("ovr_order", 8'(i));
    chk("ovr_drained", {31'd0, rx_valid}, 32'd0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    chk("pop_empty", {28'd0, rx_level}, 32'd0);
    pulse_clr();
    chk("ovr_clr", {31'd0, overrun}, 32'd0);

    // full FIFO with pop on the push cycle of 0x09
    for (int i = 0; i < 8; i++) frame(8'(i), 1'b1, n);
    chk("full_level", {28'd0, rx_level}, 32'd8);
    fork
      send(8'h09, 1'b1, 4);
      begin
        repeat (3 + 2 + 36 - 1) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    chk("pp_ovr", {31'd0, overrun}, 32'd0);
    chk("pp_level", {28'd0, rx_level}, 32'd8);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h09);
    foreach (exp_q[i]) pop_chk("pp_order", exp_q[i]);
    chk("pp_empty", {28'd0, rx_level}, 32'd0);

    // reset during data bit 4, then 0x3C at clk_div=2
    clk_div = 16'd16;
    uart_rx = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      uart_rx = 1'b1;
      repeat (16) @(posedge clk);
      #1;
    end
    uart_rx = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    resetn = 1'b0;
    uart_rx = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_mid_level", {28'd0, rx_level}, 32'd0);
    chk("rst_mid_state", {30'd0, dut.state}, 32'd0);
    clk_div = 16'd2;
    frame(8'h3C, 1'b1, n);
    chk("div2_latency", n, 41);
    chk("div2_level", {28'd0, rx_level}, 32'd1);
    pop_chk("div2_data", 8'h3C);
    chk("div2_empty", {28'd0, rx_level}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
